// File: rtl/seg7_mux_pwm.sv
// seg7_mux_pwm
//   Multiplexed N-digit 7-segment driver with prescaled refresh, per-slot PWM
//   dimming, a dark dead-time at the start of every slot, optional
//   leading-zero blanking, per-digit decimal points, an internal hex glyph
//   decoder and an end-of-frame strobe.
//
//   Scan structure: the prescaler produces one sub-tick every DIV clocks.
//   Each digit slot lasts 2^BR_W sub-ticks (pwm = 0 .. 2^BR_W-1). Digit idx
//   is lit while 1 <= pwm <= br_q; pwm == 0 is always dark, so enable never
//   overlaps between neighbouring digits.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   digits      5-bit code per digit, digit k at [5k+4:5k] (digit 0 = LSD)
//   dp_in       decimal point request per digit
//   blank_lz    enable leading-zero blanking
//   brightness  on-time in sub-ticks per slot (0 = dark), sampled per slot
//   enable      one-hot digit select (registered, polarity EN_ACTIVE_LOW)
//   segmentos   segments a..g on bits 0..6 (registered, polarity SEG_ACTIVE_LOW)
//   dp          decimal point segment (registered, polarity SEG_ACTIVE_LOW)
//   frame_tick  one-cycle pulse after the last slot of a scan wraps to digit 0
module seg7_mux_pwm #(
   parameter int N_DIG          = 3,
   parameter int DIV            = 1024,
   parameter int BR_W           = 3,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit EN_ACTIVE_LOW  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [5*N_DIG-1:0]   digits,
   input  logic [N_DIG-1:0]     dp_in,
   input  logic                 blank_lz,
   input  logic [BR_W-1:0]      brightness,
   output logic [N_DIG-1:0]     enable,
   output logic [6:0]           segmentos,
   output logic                 dp,
   output logic                 frame_tick
);

   // DIV == 1 still needs a one-bit counter; it simply stays at 0.
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = $clog2(N_DIG);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIG - 1);

   // Output levels that mean "off" for the selected polarities.
   localparam logic [N_DIG-1:0] EN_OFF  = {N_DIG{EN_ACTIVE_LOW}};
   localparam logic [6:0]       SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic             DP_OFF  = SEG_ACTIVE_LOW;

   logic [CNT_W-1:0] cnt;
   logic [BR_W-1:0]  pwm;
   logic [IDX_W-1:0] idx;
   logic [BR_W-1:0]  br_q;

   logic             tick;
   logic             pwm_last;
   logic             idx_last;
   logic             lit;

   logic [N_DIG-1:0] en_onehot;
   logic [N_DIG-1:0] lz_blank;
   logic             lz_run;
   logic [4:0]       code_sel;
   logic             dp_sel;
   logic             blank_sel;
   logic [6:0]       seg_sel;

   // Hex glyphs 0..F, 16 = blank, 17 = dash, 18..31 = blank (active-high).
   function automatic logic [6:0] glyph(input logic [4:0] code);
      logic [6:0] g;
      case (code)
         5'd0:    g = 7'h3F;
         5'd1:    g = 7'h06;
         5'd2:    g = 7'h5B;
         5'd3:    g = 7'h4F;
         5'd4:    g = 7'h66;
         5'd5:    g = 7'h6D;
         5'd6:    g = 7'h7D;
         5'd7:    g = 7'h07;
         5'd8:    g = 7'h7F;
         5'd9:    g = 7'h6F;
         5'd10:   g = 7'h77;
         5'd11:   g = 7'h7C;
         5'd12:   g = 7'h39;
         5'd13:   g = 7'h5E;
         5'd14:   g = 7'h79;
         5'd15:   g = 7'h71;
         5'd17:   g = 7'h40;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

   assign tick     = (cnt == CNT_MAX);
   assign pwm_last = &pwm;
   assign idx_last = (idx == IDX_MAX);
   assign lit      = (pwm != '0) && (pwm <= br_q);

   always_comb begin
      en_onehot = '0;
      lz_blank  = '0;
      code_sel  = '0;
      dp_sel    = 1'b0;
      blank_sel = 1'b0;
      seg_sel   = '0;

      // Walk from the most-significant digit down: blanking continues only
      // while every digit so far is a zero/blank code without a dp.
      lz_run = blank_lz;
      for (int k = N_DIG - 1; k >= 1; k--) begin
         lz_run = lz_run && !dp_in[k] &&
                  ((digits[5*k +: 5] == 5'd0) || (digits[5*k +: 5] == 5'd16));
         lz_blank[k] = lz_run;
      end

      for (int k = 0; k < N_DIG; k++) begin
         if (idx == IDX_W'(k)) begin
            en_onehot[k] = 1'b1;
            code_sel     = digits[5*k +: 5];
            dp_sel       = dp_in[k];
            blank_sel    = lz_blank[k];
         end
      end

      seg_sel = blank_sel ? 7'h00 : glyph(code_sel);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         pwm        <= '0;
         idx        <= '0;
         br_q       <= '0;
         enable     <= EN_OFF;
         segmentos  <= SEG_OFF;
         dp         <= DP_OFF;
         frame_tick <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + CNT_W'(1);

         if (tick) begin
            pwm <= pwm + BR_W'(1);
            // Brightness only changes at a slot boundary so a slot never
            // sees two different duty cycles.
            if (pwm == '0) begin
               br_q <= brightness;
            end
            if (pwm_last) begin
               idx <= idx_last ? '0 : idx + IDX_W'(1);
            end
         end

         frame_tick <= tick && pwm_last && idx_last;

         if (lit) begin
            enable    <= en_onehot ^ EN_OFF;
            segmentos <= seg_sel ^ SEG_OFF;
            dp        <= dp_sel ^ DP_OFF;
         end else begin
            enable    <= EN_OFF;
            segmentos <= SEG_OFF;
            dp        <= DP_OFF;
         end
      end
   end

endmodule

// File: tb/tb_seg7_mux_pwm.sv
// Bench for seg7_mux_pwm. Four instances cover the main configuration
// (3 digits, DIV=1), a 4-digit leading-zero case, inverted polarities and
// a prescaled (DIV=4) scan. All use BR_W=2 (4 sub-ticks per slot).
//
// Timing model used for expectations: counting edges n = 1, 2, ... after
// reset release, the outputs seen after edge n reflect the scan state of
// edge n-1: sub-tick s = (n-1)/DIV, pwm = s%4, digit = (s/4)%N_DIG.
// frame_tick is high after edge n exactly when n is a multiple of the frame
// length DIV*4*N_DIG.
module tb_seg7_mux_pwm;

   logic       clk = 1'b0;
   logic [3:0] rst_v = 4'hF;

   always #5 clk = ~clk;

   // u0: N_DIG=3, DIV=1
   logic [14:0] d0_digits = '0;
   logic [2:0]  d0_dp = '0;
   logic        d0_blz = 1'b0;
   logic [1:0]  d0_br = '0;
   logic [2:0]  en0;
   logic [6:0]  seg0;
   logic        dp0, ft0;

   // u1: N_DIG=4, DIV=1
   logic [19:0] d1_digits = '0;
   logic [3:0]  d1_dp = '0;
   logic        d1_blz = 1'b0;
   logic [1:0]  d1_br = '0;
   logic [3:0]  en1;
   logic [6:0]  seg1;
   logic        dp1, ft1;

   // u2: N_DIG=3, DIV=1, both polarities inverted
   logic [14:0] d2_digits = '0;
   logic [2:0]  d2_dp = '0;
   logic        d2_blz = 1'b0;
   logic [1:0]  d2_br = '0;
   logic [2:0]  en2;
   logic [6:0]  seg2;
   logic        dp2, ft2;

   // u3: N_DIG=3, DIV=4
   logic [14:0] d3_digits = '0;
   logic [2:0]  d3_dp = '0;
   logic        d3_blz = 1'b0;
   logic [1:0]  d3_br = '0;
   logic [2:0]  en3;
   logic [6:0]  seg3;
   logic        dp3, ft3;

   seg7_mux_pwm #(.N_DIG(3), .DIV(1), .BR_W(2), .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0)) u0 (
      .clk(clk), .rst(rst_v[0]), .digits(d0_digits), .dp_in(d0_dp), .blank_lz(d0_blz),
      .brightness(d0_br), .enable(en0), .segmentos(seg0), .dp(dp0), .frame_tick(ft0));

   seg7_mux_pwm #(.N_DIG(4), .DIV(1), .BR_W(2), .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0)) u1 (
      .clk(clk), .rst(rst_v[1]), .digits(d1_digits), .dp_in(d1_dp), .blank_lz(d1_blz),
      .brightness(d1_br), .enable(en1), .segmentos(seg1), .dp(dp1), .frame_tick(ft1));

   seg7_mux_pwm #(.N_DIG(3), .DIV(1), .BR_W(2), .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)) u2 (
      .clk(clk), .rst(rst_v[2]), .digits(d2_digits), .dp_in(d2_dp), .blank_lz(d2_blz),
      .brightness(d2_br), .enable(en2), .segmentos(seg2), .dp(dp2), .frame_tick(ft2));

   seg7_mux_pwm #(.N_DIG(3), .DIV(4), .BR_W(2), .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0)) u3 (
      .clk(clk), .rst(rst_v[3]), .digits(d3_digits), .dp_in(d3_dp), .blank_lz(d3_blz),
      .brightness(d3_br), .enable(en3), .segmentos(seg3), .dp(dp3), .frame_tick(ft3));

   // Observed outputs per instance as {enable(8), segmentos(7), dp, frame_tick}.
   logic [16:0] act [4];
   assign act[0] = {5'b0, en0, seg0, dp0, ft0};
   assign act[1] = {4'b0, en1, seg1, dp1, ft1};
   assign act[2] = {5'b0, en2, seg2, dp2, ft2};
   assign act[3] = {5'b0, en3, seg3, dp3, ft3};

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [14:0] digits;
      logic [2:0]  dp_in;
      logic        blz;
      logic [1:0]  br;
      logic [20:0] segs;   // expected glyph per digit, digit 0 in [6:0]
   } vec_t;

   vec_t tbl [14];

   function automatic logic [16:0] exp_out(input int n, input int ndig, input int div,
                                           input int br, input logic [55:0] segs,
                                           input logic [7:0] dpv, input bit seg_al,
                                           input bit en_al);
      int         s, p, i;
      logic       lit;
      logic [7:0] en;
      logic [7:0] mask;
      logic [6:0] sg;
      logic       d, f;
      s    = (n - 1) / div;
      p    = s % 4;
      i    = (s / 4) % ndig;
      lit  = (p != 0) && (p <= br);
      mask = 8'((1 << ndig) - 1);
      en   = lit ? 8'(1 << i) : 8'h00;
      if (en_al) en = ~en & mask;
      sg = lit ? segs[i*7 +: 7] : 7'h00;
      if (seg_al) sg = ~sg;
      d = lit ? dpv[i] : 1'b0;
      if (seg_al) d = ~d;
      f = ((n % (div * 4 * ndig)) == 0);
      return {en, sg, d, f};
   endfunction

   task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got {en,seg,dp,ft}=%h required %h", name, got, exp);
      end
   endtask

   // Hold reset for two edges, check the reset outputs, release just after
   // an edge so the next edge is edge 1 of the scan.
   task automatic reset_dut(input int inst, input logic [16:0] off);
      rst_v[inst] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("reset u%0d", inst), act[inst], off);
      rst_v[inst] = 1'b0;
   endtask

   task automatic run_check(input int inst, input int ndig, input int div, input int br,
                            input logic [55:0] segs, input logic [7:0] dpv,
                            input bit seg_al, input bit en_al, input int cycles,
                            input string tag);
      for (int n = 1; n <= cycles; n++) begin
         @(posedge clk);
         #1;
         check($sformatf("%s n=%0d", tag, n), act[inst],
               exp_out(n, ndig, div, br, segs, dpv, seg_al, en_al));
      end
   endtask

   initial begin
      tbl[0]  = '{{5'd2,  5'd1,  5'd0},  3'b000, 1'b0, 2'd3, {7'h5B, 7'h06, 7'h3F}};
      tbl[1]  = '{{5'd5,  5'd4,  5'd3},  3'b010, 1'b0, 2'd3, {7'h6D, 7'h66, 7'h4F}};
      tbl[2]  = '{{5'd8,  5'd7,  5'd6},  3'b000, 1'b0, 2'd2, {7'h7F, 7'h07, 7'h7D}};
      tbl[3]  = '{{5'd11, 5'd10, 5'd9},  3'b001, 1'b0, 2'd1, {7'h7C, 7'h77, 7'h6F}};
      tbl[4]  = '{{5'd14, 5'd13, 5'd12}, 3'b000, 1'b0, 2'd3, {7'h79, 7'h5E, 7'h39}};
      tbl[5]  = '{{5'd17, 5'd16, 5'd15}, 3'b000, 1'b0, 2'd3, {7'h40, 7'h00, 7'h71}};
      tbl[6]  = '{{5'd31, 5'd18, 5'd0},  3'b101, 1'b0, 2'd3, {7'h00, 7'h00, 7'h3F}};
      tbl[7]  = '{{5'd2,  5'd1,  5'd0},  3'b111, 1'b0, 2'd0, {7'h5B, 7'h06, 7'h3F}};
      tbl[8]  = '{{5'd0,  5'd0,  5'd5},  3'b000, 1'b1, 2'd3, {7'h00, 7'h00, 7'h6D}};
      tbl[9]  = '{{5'd16, 5'd0,  5'd0},  3'b000, 1'b1, 2'd3, {7'h00, 7'h00, 7'h3F}};
      tbl[10] = '{{5'd0,  5'd3,  5'd0},  3'b000, 1'b1, 2'd3, {7'h00, 7'h4F, 7'h3F}};
      tbl[11] = '{{5'd0,  5'd0,  5'd0},  3'b010, 1'b1, 2'd3, {7'h00, 7'h3F, 7'h3F}};
      tbl[12] = '{{5'd0,  5'd0,  5'd0},  3'b000, 1'b0, 2'd3, {7'h3F, 7'h3F, 7'h3F}};
      tbl[13] = '{{5'd0,  5'd0,  5'd0},  3'b100, 1'b1, 2'd3, {7'h3F, 7'h3F, 7'h3F}};

      // Table-driven: three full frames per vector on u0.
      for (int v = 0; v < 14; v++) begin
         d0_digits = tbl[v].digits;
         d0_dp     = tbl[v].dp_in;
         d0_blz    = tbl[v].blz;
         d0_br     = tbl[v].br;
         reset_dut(0, 17'h0);
         run_check(0, 3, 1, int'(tbl[v].br), {35'b0, tbl[v].segs}, {5'b0, tbl[v].dp_in},
                   1'b0, 1'b0, 36, $sformatf("vec%0d", v));
      end

      // Brightness 3 -> 1 mid-way through digit 0's slot: digit 0 keeps
      // three lit cycles, digit 1 then gets a single lit cycle.
      begin
         int exp_en [8] = '{0, 1, 1, 1, 0, 2, 0, 0};
         logic [6:0] s;
         d0_digits = {5'd2, 5'd1, 5'd0};
         d0_dp     = 3'b000;
         d0_blz    = 1'b0;
         d0_br     = 2'd3;
         reset_dut(0, 17'h0);
         for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            s = (exp_en[n-1] == 1) ? 7'h3F : (exp_en[n-1] == 2) ? 7'h06 : 7'h00;
            check($sformatf("br_change n=%0d", n), act[0], {5'b0, 3'(exp_en[n-1]), s, 2'b00});
            if (n == 2) d0_br = 2'd1;
         end
      end

      // One-cycle reset while digit 1 is lit, then the scan restarts from
      // digit 0 with post-reset timing.
      d0_br = 2'd3;
      reset_dut(0, 17'h0);
      run_check(0, 3, 1, 3, {35'b0, 7'h5B, 7'h06, 7'h3F}, 8'h00, 1'b0, 1'b0, 6, "pre_midrst");
      rst_v[0] = 1'b1;
      @(posedge clk);
      #1;
      check("midrst outputs", act[0], 17'h0);
      rst_v[0] = 1'b0;
      run_check(0, 3, 1, 3, {35'b0, 7'h5B, 7'h06, 7'h3F}, 8'h00, 1'b0, 1'b0, 24, "post_midrst");

      // Leading-zero blanking on 4 digits {0,0,7,0}.
      d1_digits = {5'd0, 5'd0, 5'd7, 5'd0};
      d1_dp     = 4'b0000;
      d1_blz    = 1'b1;
      d1_br     = 2'd3;
      reset_dut(1, 17'h0);
      run_check(1, 4, 1, 3, {28'b0, 7'h00, 7'h00, 7'h07, 7'h3F}, 8'h00, 1'b0, 1'b0, 32, "lz4");
      d1_dp = 4'b1000;
      reset_dut(1, 17'h0);
      run_check(1, 4, 1, 3, {28'b0, 7'h3F, 7'h3F, 7'h07, 7'h3F}, 8'h08, 1'b0, 1'b0, 32, "lz4_dp3");

      // Inverted polarities: codes {31,8,17}, dp on digit 1.
      d2_digits = {5'd31, 5'd8, 5'd17};
      d2_dp     = 3'b010;
      d2_blz    = 1'b0;
      d2_br     = 2'd3;
      reset_dut(2, {5'b0, 3'b111, 7'h7F, 1'b1, 1'b0});
      run_check(2, 3, 1, 3, {35'b0, 7'h00, 7'h7F, 7'h40}, 8'h02, 1'b1, 1'b1, 24, "inv");

      // Prescaled scan, DIV=4: three frames of 48 cycles.
      d3_digits = {5'd2, 5'd1, 5'd0};
      d3_dp     = 3'b100;
      d3_blz    = 1'b0;
      d3_br     = 2'd2;
      reset_dut(3, 17'h0);
      run_check(3, 3, 4, 2, {35'b0, 7'h5B, 7'h06, 7'h3F}, 8'h04, 1'b0, 1'b0, 144, "div4");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seg7_mux_pwm.md
Name: seg7_mux_pwm

Overview:
- Parametrised N-digit 7-segment multiplexer for the board's common-anode/cathode display banks.
- Scans N_DIG digits with a prescaled refresh and per-slot PWM dimming.
- Inserts a dark dead-time at the start of every slot to suppress ghosting.
- Adds optional leading-zero blanking, per-digit decimal points, an internal glyph decoder and a frame strobe.

Parameters:
- N_DIG, 3: number of digits scanned (2..8); digit 0 is the least-significant.
- DIV, 1024: clk cycles per PWM sub-tick (>=1).
- BR_W, 3: brightness width; each digit slot lasts 2^BR_W sub-ticks.
- SEG_ACTIVE_LOW, 0: 1 inverts segmentos and dp at the output.
- EN_ACTIVE_LOW, 0: 1 inverts enable at the output.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- digits  input  5*N_DIG  digit codes; digit k at [5k+4:5k].
- dp_in  input  N_DIG  decimal point request per digit.
- blank_lz  input  1  enable leading-zero blanking.
- brightness  input  BR_W  on-time in sub-ticks per slot; 0 = dark.
- enable  output  N_DIG  one-hot digit select, registered.
- segmentos  output  7  segment pattern, bit0 = a … bit6 = g, registered.
- dp  output  1  decimal point segment, registered.
- frame_tick  output  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high. All state updates on the posedge of clk.
- Reset values:
  - Prescaler, pwm, slot index and captured brightness = 0.
  - enable all inactive (0, or all 1 if EN_ACTIVE_LOW).
  - segmentos and dp off.
  - frame_tick = 0.
  - rst asserted mid-scan aborts the scan immediately; the scan restarts at digit 0, pwm 0.
- Prescaler: counts 0..DIV-1 and wraps. tick = (cnt == DIV-1). With DIV=1, tick is asserted every cycle.
- PWM counter: pwm advances on tick over 0..2^BR_W-1.
  - On wrap to 0, slot index idx advances; N_DIG-1 wraps to 0.
  - frame_tick is asserted (registered) in the cycle following the wrap from idx N_DIG-1 to 0.
- Brightness capture: brightness is captured into br_q whenever pwm==0 and tick, i.e. at the slot boundary. Changes made mid-slot take effect from the next slot.
- Enable: digit idx is lit when 1 <= pwm <= br_q.
  - pwm==0 is always dark (dead-time).
  - br_q=0 gives a fully dark display.
  - br_q=2^BR_W-1 gives the maximum duty (2^BR_W-1)/2^BR_W.
  - When dark, enable is all inactive and segmentos/dp are off.
- Latency: outputs are registered from the current idx/pwm state plus the live digits/dp_in, so there is one clk of latency after each state change.
- Decoder:
  - Codes 0–15 → hex glyphs: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
  - Code 16 → blank.
  - Code 17 → dash (0x40).
  - Codes 18–31 → blank.
  - All values are active-high, before SEG_ACTIVE_LOW inversion.
- Leading-zero blanking: when blank_lz=1, digit k (k>=1) is forced blank if:
  - its code is 0 or 16, its dp_in is 0, and
  - every higher digit j>k is also code 0 or 16 with dp_in 0.
  - Digit 0 is never blanked by this rule.
  - A digit with dp_in=1 stops blanking for itself and all lower digits.
- dp: dp = dp_in[idx] while the digit is lit; otherwise off.
- Enable order: enable is one-hot with bit idx set; never more than one bit is active in any cycle, including across slot transitions.

Test Plan:
- Reset scan: N_DIG=3, DIV=1, BR_W=2, brightness=3, digits={2,1,0}. Release rst → first output cycle is dark; then 3 cycles enable=001 with segmentos=0x3F; 1 dark cycle; 3 cycles enable=010 with 0x06; then the same for 100 with 0x5B; frame_tick is high exactly once every 12 cycles.
- Dimming: same setup, brightness=1 → each slot is 1 dark, 1 lit, 2 dark. brightness=0 → enable stays 000 for 3 full frames. A brightness change mid-slot is not applied until the next pwm==0.
- Leading-zero blanking: N_DIG=4, digits={0,0,7,0}, blank_lz=1 → digits 3 and 2 show segmentos=0, digit 1 shows 0x07, digit 0 shows 0x3F. With dp_in[3]=1 → digit 3 shows 0x3F with dp=1 and digit 2 shows 0x3F.
- Codes and polarity: codes 16, 17, 31 → 0x00, 0x40, 0x00. With SEG_ACTIVE_LOW=1 and EN_ACTIVE_LOW=1, code 8 lit → segmentos=0x00, the lit enable bit=0, others=1; during dark cycles segmentos=0x7F.
- Prescaler: DIV=4 → each sub-tick lasts exactly 4 clk cycles; frame period = 4 * 4 * N_DIG cycles for BR_W=2.
- Mid-operation reset: assert rst for 1 cycle during digit 1's lit period → the next cycle has outputs inactive and frame_tick=0; the scan then resumes from digit 0, pwm 0, with identical timing to the post-reset case.
